sr_flag_arbiter: RTL and testbench
==================================

SR_FLAG_ARBITER -- requirements
Module: sr_flag_arbiter

Interface
REQ-001 Parameter N, default 4, number of requesters sharing the flag (legal range 2..8).
REQ-002 clk  input  1  rising-edge clock.
REQ-003 rst  input  1  asynchronous active-low reset.
REQ-004 req  input  N  per-requester request; held high until its gnt bit is seen.
REQ-005 s  input  N  per-requester set command, sampled with req.
REQ-006 r  input  N  per-requester reset command, sampled with req.
REQ-007 q  output  1  shared SR flag state, registered.
REQ-008 gnt  output  N  one-hot grant/acknowledge, registered, one-cycle pulse.
REQ-009 err  output  1  one-cycle pulse, concurrent with gnt, when the granted command was s=1, r=1.
REQ-010 busy  output  1  high whenever state is APPLY.

Function
REQ-011 The FSM SHALL have two states: IDLE and APPLY.
REQ-012 IDLE, eligible = req & ~gnt, none set: SHALL stay in IDLE, no output change except gnt/err clear to 0.
REQ-013 IDLE, eligible nonzero at edge E0: SHALL latch winner index, winner s and winner r, and go to APPLY.
REQ-014 The winner SHALL be the first eligible index at or after ptr, scanning upward modulo N.
REQ-015 APPLY at edge E1: SHALL update q, pulse gnt[winner], set ptr = (winner+1) mod N, and return to IDLE.
REQ-016 q update at E1: s=1,r=0 -> q=1; s=0,r=1 -> q=0; s=0,r=0 -> q unchanged (hold).
REQ-017 s=1,r=1 SHALL leave q unchanged and assert err for the same cycle as gnt.
REQ-018 Latency: req sampled at E0 -> q and gnt valid after E1. Maximum throughput is one grant per 2 cycles.
REQ-019 gnt and err SHALL deassert at E2. A new arbitration MAY begin at E2 (back-to-back grants every 2 cycles).
REQ-020 The requester holding gnt SHALL be masked out of arbitration at E2, so a req dropped one cycle late is not re-granted.
REQ-021 req, s or r changes after E0 SHALL NOT affect the latched command.
REQ-022 ptr wrap: after a grant to index N-1, ptr SHALL become 0.
REQ-023 Only one gnt bit SHALL ever be high, and gnt SHALL be 0 whenever busy=1.

Reset
REQ-024 When rst is low, the block SHALL asynchronously force state=IDLE, ptr=0, q=0, gnt=0, err=0 and busy=0.
REQ-025 Reset during APPLY SHALL discard the latched command; q SHALL stay 0.
REQ-026 After rst rises, arbitration SHALL start on the first rising clk edge with rst high.

Structure
REQ-027 A shared package SHALL hold the FSM state encoding (IDLE=0, APPLY=1) and the 2-bit command encoding {s,r}: HOLD=00, CLR=01, SET=10, BAD=11.
REQ-028 Round-robin selection SHALL be a separate combinational sub-module, rr_pick (inputs: eligible vector, ptr; outputs: found, index).
REQ-029 ptr width SHALL be clog2(N). Target size is 120-250 lines of RTL in total.

Verification
REQ-030 Reset: rst=0 for 3 ns with req=4'b1111 -> q=0, gnt=0, busy=0; no grant while reset is held.
REQ-031 Single requester: req[2]=1, s[2]=1 sampled at E0 -> busy=1 after E0; after E1 q=1, gnt=4'b0100, err=0; after E2 gnt=0.
REQ-032 Fairness: req=4'b1111 held with all commands HOLD -> gnt sequence 0001, 0010, 0100, 1000, 0001, spaced 2 cycles apart.
REQ-033 Illegal command: q=1, then req[0] with s=1,r=1 -> gnt=0001, err=1 for one cycle, q stays 1.
REQ-034 Set/clear ordering: req[1] SET and req[3] CLR together with ptr=0 -> index 1 is granted first (q=1), then index 3 (q=0).
REQ-035 Reset mid-APPLY: rst pulsed low between E0 and E1 of a SET grant -> q=0, gnt=0, and the next grant starts from ptr=0.

Source files
------------

// File: rtl/sr_flag_arbiter_pkg.sv
// rtl/sr_flag_arbiter_pkg.sv - shared state/command encodings for the SR flag arbiter
package sr_flag_arbiter_pkg;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_APPLY = 1'b1
    } state_e;

    // Command as seen on {s, r} of the winning requester.
    typedef enum logic [1:0] {
        CMD_HOLD = 2'b00,
        CMD_CLR  = 2'b01,
        CMD_SET  = 2'b10,
        CMD_BAD  = 2'b11
    } cmd_e;

    // Next flag value for a command; HOLD and BAD both leave the flag alone.
    function automatic logic apply_cmd(input cmd_e cmd, input logic q_cur);
        logic q_nxt;
        q_nxt = q_cur;
        case (cmd)
            CMD_SET: q_nxt = 1'b1;
            CMD_CLR: q_nxt = 1'b0;
            default: q_nxt = q_cur;
        endcase
        return q_nxt;
    endfunction

endpackage

// File: rtl/sr_flag_arbiter_rr_pick.sv
// rtl/sr_flag_arbiter_rr_pick.sv - combinational round-robin pick starting at ptr
module rr_pick #(
    parameter int N = 4
) (
    input  logic [N-1:0]         eligible_i,
    input  logic [$clog2(N)-1:0] ptr_i,
    output logic                 found_o,
    output logic [$clog2(N)-1:0] index_o
);

    localparam int PW = $clog2(N);

    logic [PW:0]   sum;
    logic [PW-1:0] pos;

    // Scan upward from ptr modulo N and keep the first eligible index.
    always_comb begin
        found_o = 1'b0;
        index_o = '0;
        sum     = '0;
        pos     = '0;
        for (int k = 0; k < N; k++) begin
            sum = {1'b0, ptr_i} + (PW+1)'(k);
            if (sum >= (PW+1)'(N)) begin
                sum = sum - (PW+1)'(N);
            end
            pos = sum[PW-1:0];
            if (!found_o && eligible_i[pos]) begin
                found_o = 1'b1;
                index_o = pos;
            end
        end
    end

endmodule

// File: rtl/sr_flag_arbiter.sv
// rtl/sr_flag_arbiter.sv - round-robin arbiter applying set/reset commands to one shared flag
module sr_flag_arbiter
    import sr_flag_arbiter_pkg::*;
#(
    parameter int N = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [N-1:0] req,
    input  logic [N-1:0] s,
    input  logic [N-1:0] r,
    output logic         q,
    output logic [N-1:0] gnt,
    output logic         err,
    output logic         busy
);

    localparam int PW = $clog2(N);

    state_e        state_q, state_d;
    logic [PW-1:0] ptr_q, ptr_d;
    logic [PW-1:0] win_idx_q, win_idx_d;
    cmd_e          win_cmd_q, win_cmd_d;
    logic          q_q, q_d;
    logic [N-1:0]  gnt_q, gnt_d;
    logic          err_q, err_d;

    logic [N-1:0]  eligible;
    logic          pick_found;
    logic [PW-1:0] pick_idx;
    logic [PW-1:0] ptr_after_win;

    // The requester currently acknowledged may still show req this cycle; keep it out.
    assign eligible = req & ~gnt_q;

    rr_pick #(
        .N(N)
    ) u_pick (
        .eligible_i (eligible),
        .ptr_i      (ptr_q),
        .found_o    (pick_found),
        .index_o    (pick_idx)
    );

    assign ptr_after_win = (win_idx_q == PW'(N - 1)) ? '0 : win_idx_q + PW'(1);

    // Next-state logic: latch the winner in IDLE, commit its command in APPLY.
    always_comb begin
        state_d   = state_q;
        ptr_d     = ptr_q;
        win_idx_d = win_idx_q;
        win_cmd_d = win_cmd_q;
        q_d       = q_q;
        gnt_d     = '0;
        err_d     = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (pick_found) begin
                    win_idx_d = pick_idx;
                    win_cmd_d = cmd_e'({s[pick_idx], r[pick_idx]});
                    state_d   = ST_APPLY;
                end
            end
            ST_APPLY: begin
                q_d              = apply_cmd(win_cmd_q, q_q);
                gnt_d[win_idx_q] = 1'b1;
                err_d            = (win_cmd_q == CMD_BAD);
                ptr_d            = ptr_after_win;
                state_d          = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State registers; reset drops any latched command so the flag stays cleared.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= ST_IDLE;
            ptr_q     <= '0;
            win_idx_q <= '0;
            win_cmd_q <= CMD_HOLD;
            q_q       <= 1'b0;
            gnt_q     <= '0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            ptr_q     <= ptr_d;
            win_idx_q <= win_idx_d;
            win_cmd_q <= win_cmd_d;
            q_q       <= q_d;
            gnt_q     <= gnt_d;
            err_q     <= err_d;
        end
    end

    assign q    = q_q;
    assign gnt  = gnt_q;
    assign err  = err_q;
    assign busy = (state_q == ST_APPLY);

endmodule

// File: tb/tb_sr_flag_arbiter.sv
// tb/tb_sr_flag_arbiter.sv - directed self-checking bench for sr_flag_arbiter
module tb_sr_flag_arbiter;

    logic       clk;
    logic       rst;
    logic [3:0] req;
    logic [3:0] s;
    logic [3:0] r;
    logic       q;
    logic [3:0] gnt;
    logic       err;
    logic       busy;

    int n_checks;
    int n_errors;

    sr_flag_arbiter #(
        .N(4)
    ) dut (
        .clk  (clk),
        .rst  (rst),
        .req  (req),
        .s    (s),
        .r    (r),
        .q    (q),
        .gnt  (gnt),
        .err  (err),
        .busy (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_reset();
        rst = 1'b0;
        #1;
        chk("pulse_rst_q", 32'(q), 0);
        chk("pulse_rst_gnt", 32'(gnt), 0);
        rst = 1'b1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        logic [3:0] fair_exp [5];
        fair_exp[0] = 4'b0001;
        fair_exp[1] = 4'b0010;
        fair_exp[2] = 4'b0100;
        fair_exp[3] = 4'b1000;
        fair_exp[4] = 4'b0001;
        n_checks = 0;
        n_errors = 0;

        // Reset held with all requests active
        rst = 1'b0;
        req = 4'b1111;
        s   = 4'b0000;
        r   = 4'b0000;
        #3;
        chk("rst_q", 32'(q), 0);
        chk("rst_gnt", 32'(gnt), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_err", 32'(err), 0);
        tick();
        tick();
        chk("rst_hold_gnt", 32'(gnt), 0);
        chk("rst_hold_busy", 32'(busy), 0);

        // Single requester SET on index 2; late s/r change must be ignored
        req = 4'b0100;
        s   = 4'b0100;
        r   = 4'b0000;
        rst = 1'b1;
        tick();
        chk("single_e0_busy", 32'(busy), 1);
        chk("single_e0_gnt", 32'(gnt), 0);
        s = 4'b0000;
        r = 4'b0100;
        tick();
        chk("single_e1_q", 32'(q), 1);
        chk("single_e1_gnt", 32'(gnt), 32'h4);
        chk("single_e1_err", 32'(err), 0);
        chk("single_e1_busy", 32'(busy), 0);
        s = 4'b0000;
        r = 4'b0000;
        tick();
        chk("single_e2_gnt", 32'(gnt), 0);
        chk("single_e2_masked", 32'(busy), 0);
        req = 4'b0000;
        tick();
        chk("single_idle_busy", 32'(busy), 0);
        chk("single_idle_q", 32'(q), 1);

        // Fairness from ptr=0, all HOLD
        pulse_reset();
        req = 4'b1111;
        for (int i = 0; i < 5; i++) begin
            tick();
            chk($sformatf("fair%0d_busy", i), 32'(busy), 1);
            chk($sformatf("fair%0d_gnt_low", i), 32'(gnt), 0);
            tick();
            chk($sformatf("fair%0d_gnt", i), 32'(gnt), 32'(fair_exp[i]));
            chk($sformatf("fair%0d_q", i), 32'(q), 0);
        end
        req = 4'b0000;
        tick();
        chk("fair_end_gnt", 32'(gnt), 0);
        chk("fair_end_busy", 32'(busy), 0);

        // Illegal command with q=1 (ptr=1 here)
        req = 4'b0010;
        s   = 4'b0010;
        tick();
        tick();
        chk("bad_pre_gnt", 32'(gnt), 32'h2);
        chk("bad_pre_q", 32'(q), 1);
        req = 4'b0001;
        s   = 4'b0001;
        r   = 4'b0001;
        tick();
        chk("bad_e0_busy", 32'(busy), 1);
        tick();
        chk("bad_e1_gnt", 32'(gnt), 32'h1);
        chk("bad_e1_err", 32'(err), 1);
        chk("bad_e1_q", 32'(q), 1);
        req = 4'b0000;
        s   = 4'b0000;
        r   = 4'b0000;
        tick();
        chk("bad_e2_err", 32'(err), 0);
        chk("bad_e2_gnt", 32'(gnt), 0);
        chk("bad_e2_q", 32'(q), 1);

        // Set/clear ordering from ptr=0
        pulse_reset();
        req = 4'b1010;
        s   = 4'b0010;
        r   = 4'b1000;
        tick();
        tick();
        chk("order_first_gnt", 32'(gnt), 32'h2);
        chk("order_first_q", 32'(q), 1);
        req = 4'b1000;
        tick();
        chk("order_second_busy", 32'(busy), 1);
        tick();
        chk("order_second_gnt", 32'(gnt), 32'h8);
        chk("order_second_q", 32'(q), 0);

        // ptr wraps to 0 after granting index 3
        req = 4'b0011;
        s   = 4'b0000;
        r   = 4'b0000;
        tick();
        chk("wrap_busy", 32'(busy), 1);
        tick();
        chk("wrap_gnt", 32'(gnt), 32'h1);

        // Reset between E0 and E1 of a SET grant to index 2
        req = 4'b0100;
        s   = 4'b0100;
        tick();
        chk("midrst_e0_busy", 32'(busy), 1);
        #2;
        rst = 1'b0;
        #1;
        chk("midrst_q", 32'(q), 0);
        chk("midrst_gnt", 32'(gnt), 0);
        chk("midrst_busy", 32'(busy), 0);
        #1;
        rst = 1'b1;
        req = 4'b1111;
        s   = 4'b0000;
        r   = 4'b0000;
        tick();
        chk("midrst_after_busy", 32'(busy), 1);
        chk("midrst_after_q", 32'(q), 0);
        tick();
        chk("midrst_after_gnt", 32'(gnt), 32'h1);
        chk("midrst_after_q2", 32'(q), 0);
        req = 4'b0000;
        tick();

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
